lut_index_encoder: RTL and testbench

- Inverse of the branch-target LUT: accepts a 10-bit branch target/offset and returns the 4-bit LUT index that decodes to it.
- Owns a programmable 16-entry target table. A multi-cycle FSM searches the table and, on a miss with allocation enabled, appends the target as a new entry.
- Sits between the instruction encoder/assembler-side datapath and the program's branch LUT, so encoded branch fields and LUT contents stay consistent.

---
 rtl/lut_index_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_lut_index_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_index_encoder.sv
// -----------------------------------------------------------------------------
// lut_index_encoder
//
// Inverse of the branch-target LUT: maps a TW-bit branch target/offset to the
// IW-bit LUT index that decodes back to it. Owns a programmable DEPTH-entry
// target table. A multi-cycle FSM walks the valid entries one per cycle. On a
// miss with allocation enabled, it appends the target as a new entry.
//
// Build option:
//   LUT_ENC_PRELOAD_EN  when defined, Reset loads the default branch set
//                       (3F0, 003, 007, 001) into entries 0-3 and sets
//                       Count=4. Otherwise Reset clears the table and sets
//                       Count=0.
//
// Ports:
//   Clk       in   rising-edge clock
//   Reset     in   synchronous, active-high
//   Req       in   start a lookup (sampled only in IDLE)
//   Target    in   TW-bit value to look up (latched on the accepting edge)
//   Alloc     in   allow append on miss (latched with Target)
//   Busy      out  high whenever the FSM is not in IDLE
//   Done      out  one-cycle pulse when Hit/Index are valid
//   Hit       out  target found or allocated (held until the next Done)
//   Index     out  resulting index, 0 on failure (held until the next Done)
//   Full      out  Count == DEPTH
//   Count     out  number of valid entries
//   RdAddr    in   debug/mirror read address
//   RdTarget  out  combinational table[RdAddr]
// -----------------------------------------------------------------------------
module lut_index_encoder #(
    parameter int DEPTH = 16,
    parameter int IW    = 4,
    parameter int TW    = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Req,
    input  logic [TW-1:0] Target,
    input  logic          Alloc,
    output logic          Busy,
    output logic          Done,
    output logic          Hit,
    output logic [IW-1:0] Index,
    output logic          Full,
    output logic [IW:0]   Count,
    input  logic [IW-1:0] RdAddr,
    output logic [TW-1:0] RdTarget
);

    localparam logic [IW:0] C_DEPTH = (IW+1)'(DEPTH);
    localparam logic [IW:0] C_ONE   = (IW+1)'(1);

`ifdef LUT_ENC_PRELOAD_EN
    localparam logic [IW:0] C_RESET_COUNT = (IW+1)'(4);
`else
    localparam logic [IW:0] C_RESET_COUNT = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_ALLOC,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [TW-1:0] r_table [DEPTH];
    logic [IW:0]   r_count;
    logic [IW-1:0] r_ptr;
    logic [TW-1:0] r_target;
    logic          r_alloc;
    logic          r_hit;
    logic [IW-1:0] r_index;

    logic          w_full;
    logic          w_match;
    logic          w_last;
    logic          w_accept;
    logic          w_ptr_inc;
    logic          w_set_hit;
    logic          w_set_miss;
    logic          w_do_alloc;

    assign w_full  = (r_count == C_DEPTH);
    // An empty table has no valid entry 0, so a zero target must not match it.
    assign w_match = (r_count != '0) && (r_table[r_ptr] == r_target);
    assign w_last  = (r_count == '0) || ({1'b0, r_ptr} == (r_count - C_ONE));

    // Next-state and control decode
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ptr_inc    = 1'b0;
        w_set_hit    = 1'b0;
        w_set_miss   = 1'b0;
        w_do_alloc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Req) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_match) begin
                    w_set_hit    = 1'b1;
                    w_state_next = S_DONE;
                end else if (w_last) begin
                    if (r_alloc && !w_full) begin
                        w_state_next = S_ALLOC;
                    end else begin
                        w_set_miss   = 1'b1;
                        w_state_next = S_DONE;
                    end
                end else begin
                    w_ptr_inc = 1'b1;
                end
            end
            S_ALLOC: begin
                w_do_alloc   = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request operands: only meaningful after acceptance, so no reset needed
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_target <= Target;
            r_alloc  <= Alloc;
        end
    end

    // Table, entry count, search pointer and result registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr   <= '0;
            r_hit   <= 1'b0;
            r_index <= '0;
            r_count <= C_RESET_COUNT;
            for (int k = 0; k < DEPTH; k++) begin
                r_table[k] <= '0;
            end
`ifdef LUT_ENC_PRELOAD_EN
            r_table[0] <= TW'(10'h3F0);
            r_table[1] <= TW'(10'h003);
            r_table[2] <= TW'(10'h007);
            r_table[3] <= TW'(10'h001);
`endif
        end else begin
            if (w_accept) begin
                r_ptr <= '0;
            end
            if (w_ptr_inc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_set_hit) begin
                r_hit   <= 1'b1;
                r_index <= r_ptr;
            end
            if (w_set_miss) begin
                r_hit   <= 1'b0;
                r_index <= '0;
            end
            // ALLOC is only entered when not full, so Count[IW-1:0] is a
            // valid free slot here.
            if (w_do_alloc) begin
                r_table[r_count[IW-1:0]] <= r_target;
                r_index                  <= r_count[IW-1:0];
                r_hit                    <= 1'b1;
                r_count                  <= r_count + C_ONE;
            end
        end
    end

    assign Busy     = (r_state != S_IDLE);
    assign Done     = (r_state == S_DONE);
    assign Hit      = r_hit;
    assign Index    = r_index;
    assign Full     = w_full;
    assign Count    = r_count;
    assign RdTarget = r_table[RdAddr];

endmodule

// File: tb/tb_lut_index_encoder.sv
// -----------------------------------------------------------------------------
// tb_lut_index_encoder
//
// Directed self-checking bench for lut_index_encoder. It covers reset state,
// lookup latency and results, allocation up to Full, behaviour on a full
// table, Req/Target changes while busy, and Reset in the middle of a search.
// Builds with or without LUT_ENC_PRELOAD_EN; PRE is the reset entry count.
// -----------------------------------------------------------------------------
module tb_lut_index_encoder;

    localparam int DEPTH = 16;
    localparam int IW    = 4;
    localparam int TW    = 10;

`ifdef LUT_ENC_PRELOAD_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 0;
`endif

    logic          Clk;
    logic          Reset;
    logic          Req;
    logic [TW-1:0] Target;
    logic          Alloc;
    logic          Busy;
    logic          Done;
    logic          Hit;
    logic [IW-1:0] Index;
    logic          Full;
    logic [IW:0]   Count;
    logic [IW-1:0] RdAddr;
    logic [TW-1:0] RdTarget;

    int vectors     = 0;
    int miscompares = 0;

    lut_index_encoder #(.DEPTH(DEPTH), .IW(IW), .TW(TW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Target   (Target),
        .Alloc    (Alloc),
        .Busy     (Busy),
        .Done     (Done),
        .Hit      (Hit),
        .Index    (Index),
        .Full     (Full),
        .Count    (Count),
        .RdAddr   (RdAddr),
        .RdTarget (RdTarget)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for Done. Returns the number of
    // cycles from the accepting edge to the Done cycle; 40 means no Done.
    // Target/Alloc are scrambled right after acceptance.
    task automatic run_req(input logic [TW-1:0] t, input logic a,
                           output int cyc, output logic hit, output logic [IW-1:0] idx,
                           output logic busy1, output logic busy_done);
        logic got;
        @(negedge Clk);
        Req = 1'b1; Target = t; Alloc = a;
        @(posedge Clk);
        #1;
        Req = 1'b0; Target = ~t; Alloc = ~a;
        cyc = 0; got = 1'b0; hit = 1'b0; idx = '0; busy1 = 1'b0; busy_done = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) busy1 = Busy;
            if (Done) begin
                got = 1'b1; hit = Hit; idx = Index; busy_done = Busy;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    function automatic logic [TW-1:0] tgt(input int k);
        return TW'(10'h010 + k);
    endfunction

    initial begin
        int            cyc;
        logic          hit;
        logic [IW-1:0] idx;
        logic          b1;
        logic          bd;
        int            seen;

        Reset = 1'b0; Req = 1'b0; Target = '0; Alloc = 1'b0; RdAddr = '0;

        // Reset state
        do_reset();
        check("rst_busy",  16'(Busy),  16'h0);
        check("rst_done",  16'(Done),  16'h0);
        check("rst_hit",   16'(Hit),   16'h0);
        check("rst_index", 16'(Index), 16'h0);
        check("rst_count", 16'(Count), 16'(PRE));
        check("rst_full",  16'(Full),  16'h0);
        RdAddr = 4'd0;
        #1;
`ifdef LUT_ENC_PRELOAD_EN
        check("rst_rd0", 16'(RdTarget), 16'h3F0);
        RdAddr = 4'd3;
        #1;
        check("rst_rd3", 16'(RdTarget), 16'h001);

        // Preloaded entry 2 hit: 2+2 cycles
        run_req(10'h007, 1'b0, cyc, hit, idx, b1, bd);
        check("pre_007_cyc",   16'(cyc),   16'd4);
        check("pre_007_hit",   16'(hit),   16'h1);
        check("pre_007_idx",   16'(idx),   16'h2);
        check("pre_007_count", 16'(Count), 16'd4);
        check("pre_007_busy1", 16'(b1),    16'h1);
        check("pre_007_busyd", 16'(bd),    16'h1);
`else
        check("rst_rd0", 16'(RdTarget), 16'h0);

        // Empty table miss without allocation: minimum 2 cycles
        run_req(10'h3F0, 1'b0, cyc, hit, idx, b1, bd);
        check("empty_miss_cyc",   16'(cyc),   16'd2);
        check("empty_miss_hit",   16'(hit),   16'h0);
        check("empty_miss_idx",   16'(idx),   16'h0);
        check("empty_miss_count", 16'(Count), 16'd0);
        check("empty_miss_busy1", 16'(b1),    16'h1);
        check("empty_miss_busyd", 16'(bd),    16'h1);

        // Empty table miss with allocation; write visible in the Done cycle
        RdAddr = 4'd0;
        run_req(10'h3F0, 1'b1, cyc, hit, idx, b1, bd);
        check("empty_alloc_done",  16'(cyc < 40), 16'h1);
        check("empty_alloc_hit",   16'(hit),      16'h1);
        check("empty_alloc_idx",   16'(idx),      16'h0);
        check("empty_alloc_count", 16'(Count),    16'd1);
        check("empty_alloc_rd0",   16'(RdTarget), 16'h3F0);
`endif

        // Fill the table from the reset state: 010, 011, ... then 020 once full
        do_reset();
        for (int k = 0; k <= DEPTH - PRE; k++) begin
            RdAddr = IW'(PRE + k);
            run_req(tgt(k == DEPTH - PRE ? 16 : k), 1'b1, cyc, hit, idx, b1, bd);
            if (k < DEPTH - PRE) begin
                if (PRE + k > 0) check($sformatf("alloc%0d_cyc", k), 16'(cyc), 16'(PRE + k + 2));
                check($sformatf("alloc%0d_hit", k),   16'(hit),      16'h1);
                check($sformatf("alloc%0d_idx", k),   16'(idx),      16'(PRE + k));
                check($sformatf("alloc%0d_count", k), 16'(Count),    16'(PRE + k + 1));
                check($sformatf("alloc%0d_rd", k),    16'(RdTarget), 16'(tgt(k)));
            end else begin
                check("full_alloc_cyc",   16'(cyc),   16'd17);
                check("full_alloc_hit",   16'(hit),   16'h0);
                check("full_alloc_idx",   16'(idx),   16'h0);
                check("full_alloc_count", 16'(Count), 16'd16);
                check("full_alloc_full",  16'(Full),  16'h1);
            end
        end
        RdAddr = 4'd15;
        #1;
        check("full_rd15", 16'(RdTarget), 16'(tgt(DEPTH - 1 - PRE)));

        // Deepest entry hit: 15+2 cycles
        run_req(tgt(DEPTH - 1 - PRE), 1'b0, cyc, hit, idx, b1, bd);
        check("hit15_cyc", 16'(cyc), 16'd17);
        check("hit15_hit", 16'(hit), 16'h1);
        check("hit15_idx", 16'(idx), 16'd15);

        // Existing entry with Alloc=1 must hit without growing the table
        run_req(tgt(0), 1'b1, cyc, hit, idx, b1, bd);
        check("hitpre_cyc",   16'(cyc),   16'(PRE + 2));
        check("hitpre_idx",   16'(idx),   16'(PRE));
        check("hitpre_hit",   16'(hit),   16'h1);
        check("hitpre_count", 16'(Count), 16'd16);

        // Req held and Target/Alloc changed while busy: result follows the
        // originally latched target at index 5
        @(negedge Clk);
        Req = 1'b1; Target = tgt(5 - PRE); Alloc = 1'b0;
        @(posedge Clk);
        #1;
        Target = 10'h3FF; Alloc = 1'b1;
        cyc = 0; seen = 0;
        while (seen == 0 && cyc < 40) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 3) Req = 1'b0;
            if (Done) begin
                seen = 1; hit = Hit; idx = Index;
            end
        end
        check("busyreq_cyc", 16'(cyc), 16'd7);
        check("busyreq_hit", 16'(hit), 16'h1);
        check("busyreq_idx", 16'(idx), 16'd5);
        @(negedge Clk);
        check("busyreq_idle", 16'(Busy), 16'h0);

        // Reset in the middle of a long search
        @(negedge Clk);
        Req = 1'b1; Target = tgt(DEPTH - 1 - PRE); Alloc = 1'b0;
        @(posedge Clk);
        #1;
        Req = 1'b0;
        repeat (4) @(negedge Clk);
        check("midrst_busy_before", 16'(Busy), 16'h1);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_busy",  16'(Busy),     16'h0);
        check("midrst_done",  16'(Done),     16'h0);
        check("midrst_count", 16'(Count),    16'(PRE));
        check("midrst_full",  16'(Full),     16'h0);
        check("midrst_hit",   16'(Hit),      16'h0);
        check("midrst_rd15",  16'(RdTarget), 16'h0);
        Reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge Clk);
            if (Done || Busy) seen++;
        end
        check("midrst_quiet", 16'(seen), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
